// File: rtl/fir_param_pkg.sv
// Shared FIR parameters and sample type for the FIR output stage.
// INPUT_WORD_SIZE falls back to 8 bits when the build does not define it.
`ifndef INPUT_WORD_SIZE
`define INPUT_WORD_SIZE 8
`endif

package fir_param_pkg;
    localparam int FIR_COEF_SHIFT = 8;
    localparam int FIR_SUM_W      = 18;
    localparam int FIR_OUT_W      = `INPUT_WORD_SIZE;
    localparam int FIR_DECIM      = 2;
    localparam int FIR_FIFO_DEPTH = 4;

    typedef logic [`INPUT_WORD_SIZE-1:0] fir_out_t;
endpackage

// File: rtl/fir_decim_out_if.sv
// Output stream toward the consumer.
// Valid/ready: a word moves when m_valid_out && m_ready_in at a clock edge; the producer holds
// m_data_out stable while m_valid_out is high and m_ready_in is low.
interface fir_decim_out_if
    import fir_param_pkg::*;
#(
    parameter int OUT_W = FIR_OUT_W
);
    logic [OUT_W-1:0] m_data_out;
    logic             m_valid_out;
    logic             m_ready_in;

    modport master (output m_data_out, output m_valid_out, input m_ready_in);
    modport slave  (input m_data_out, input m_valid_out, output m_ready_in);
endinterface

// File: rtl/fir_dec_fifo.sv
// Generic first-word-fall-through synchronous FIFO with async reset and sync clear.
// Read data is forced to 0 while empty.
module fir_dec_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr,
    input  logic [W-1:0]             wdata,
    input  logic                     rd,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_cnt;
    logic [AW:0]  rd_cnt;
    logic         wr_ok;
    logic         rd_ok;

    assign level = wr_cnt - rd_cnt;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    // A write into a full FIFO is still accepted when the head leaves on the same edge.
    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd_ok);
    assign rdata = empty ? '0 : mem[rd_cnt[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else if (clr) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (wr_ok) wr_cnt <= wr_cnt + 1'b1;
            if (rd_ok) rd_cnt <= rd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !clr) mem[wr_cnt[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/fir_decim_out.sv
// FIR output stage: rescale by SHIFT, saturate, decimate by DECIM, buffer in an FWFT FIFO.
// FIR_DEC_ROUND_EN selects round-half-up before the shift; otherwise the shift truncates.
module fir_decim_out
    import fir_param_pkg::*;
#(
    parameter int IN_W       = FIR_SUM_W,
    parameter int OUT_W      = FIR_OUT_W,
    parameter int SHIFT      = FIR_COEF_SHIFT,
    parameter int DECIM      = FIR_DECIM,
    parameter int FIFO_DEPTH = FIR_FIFO_DEPTH
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          valid_in,
    input  logic [IN_W-1:0]               data_in,
    input  logic                          clear_in,
    fir_decim_out_if.master               m,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
    output logic                          overflow_out
);
    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [IN_W:0] SAT_MAX = (IN_W+1)'((2 ** OUT_W) - 1);
`ifdef FIR_DEC_ROUND_EN
    localparam logic [IN_W:0] RND = (IN_W+1)'(1) << (SHIFT - 1);
`else
    localparam logic [IN_W:0] RND = '0;
`endif

    logic [DCNT_W-1:0] dcnt;
    logic              keep;
    logic [IN_W:0]     sum_w;
    logic [IN_W:0]     shifted;
    logic [OUT_W-1:0]  sat;
    logic              pipe_vld;
    logic [OUT_W-1:0]  pipe_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    // One extra bit keeps the rounding carry of a near-full-scale sum.
    assign sum_w   = {1'b0, data_in} + RND;
    assign shifted = sum_w >> SHIFT;
    assign sat     = (shifted > SAT_MAX) ? '1 : shifted[OUT_W-1:0];
    assign keep    = valid_in && (dcnt == '0);
    assign pop     = m.m_valid_out && m.m_ready_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dcnt         <= '0;
            pipe_vld     <= 1'b0;
            pipe_data    <= '0;
            overflow_out <= 1'b0;
        end else if (clear_in) begin
            dcnt         <= '0;
            pipe_vld     <= 1'b0;
            pipe_data    <= '0;
            overflow_out <= 1'b0;
        end else begin
            if (valid_in)
                dcnt <= (dcnt == DCNT_W'(DECIM - 1)) ? '0 : dcnt + 1'b1;
            pipe_vld <= keep;
            if (keep) pipe_data <= sat;
            if (pipe_vld && fifo_full && !pop) overflow_out <= 1'b1;
        end
    end

    fir_dec_fifo #(
        .W     (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .clr   (clear_in),
        .wr    (pipe_vld),
        .wdata (pipe_data),
        .rd    (m.m_ready_in),
        .rdata (m.m_data_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level_out)
    );

    assign m.m_valid_out = !fifo_empty;
endmodule

// File: tb/tb_fir_decim_out.sv
// Bench for fir_decim_out: directed cases plus random traffic against a queue-based model.
module tb_fir_decim_out;
  import fir_param_pkg::*;

  localparam int IN_W  = 18;
  localparam int OUT_W = 8;
  localparam int DEPTH = 4;
  localparam int DECIM = 2;
`ifdef FIR_DEC_ROUND_EN
  localparam int RND_TB = 128;
`else
  localparam int RND_TB = 0;
`endif

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             valid_in;
  logic [IN_W-1:0]  data_in;
  logic             clear_in;
  logic [2:0]       fifo_level_out;
  logic             overflow_out;

  fir_decim_out_if #(.OUT_W(OUT_W)) mif ();

  fir_decim_out dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .clear_in       (clear_in),
    .m              (mif),
    .fifo_level_out (fifo_level_out),
    .overflow_out   (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected output words in order of FIFO entry.
  logic [OUT_W-1:0] exp_q[$];

  // Reference model state: occupancy, count of valid samples, pending scaled sample, sticky drop.
  int               m_level;
  int               m_vcnt;
  bit               m_ovf;
  bit               m_pipe_vld;
  logic [OUT_W-1:0] m_pipe_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] ref_scale(input int x);
    int v;
    v = (x + RND_TB) / 256;
    if (v > 255) v = 255;
    return OUT_W'(v);
  endfunction

  // Model: keep every DECIM-th valid sample, scale it, enter it into a bounded queue one cycle later.
  always begin
    bit pop;
    @(posedge clk_in or posedge rst_in);
    if (rst_in || clear_in) begin
      m_level = 0; m_vcnt = 0; m_ovf = 0; m_pipe_vld = 0; m_pipe_val = '0;
      exp_q.delete();
    end else begin
      pop = (m_level > 0) && mif.m_ready_in;
      if (m_pipe_vld) begin
        if (m_level < DEPTH || pop) begin
          exp_q.push_back(m_pipe_val);
          m_level++;
        end else begin
          m_ovf = 1;
        end
      end
      if (pop) m_level--;
      m_pipe_vld = valid_in && (m_vcnt % DECIM == 0);
      m_pipe_val = ref_scale(int'(data_in));
      if (valid_in) m_vcnt++;
    end
  end

  // Monitor: compares DUT outputs with the model and pops the scoreboard on every transfer.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      check("valid", 32'(mif.m_valid_out), 32'(m_level > 0));
      check("level", 32'(fifo_level_out), 32'(m_level));
      check("overflow", 32'(overflow_out), 32'(m_ovf));
      if (!mif.m_valid_out) begin
        check("data_idle", 32'(mif.m_data_out), 32'd0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(mif.m_data_out), 32'hFFFF_FFFF);
      end else if (mif.m_ready_in) begin
        check("data_pop", 32'(mif.m_data_out), 32'(exp_q.pop_front()));
      end else begin
        check("data_hold", 32'(mif.m_data_out), 32'(exp_q[0]));
      end
    end
  end

  // Drive one cycle of inputs; returns 2 time units after the edge that samples them.
  task automatic cyc(input logic v, input logic [IN_W-1:0] d, input logic c, input logic r);
    valid_in       = v;
    data_in        = d;
    clear_in       = c;
    mif.m_ready_in = r;
    @(posedge clk_in);
    #2;
  endtask

  task automatic expect_head(input string tag, input logic [OUT_W-1:0] e);
    check({tag, "_valid"}, 32'(mif.m_valid_out), 32'd1);
    check({tag, "_data"}, 32'(mif.m_data_out), 32'(e));
  endtask

  // Single sample into an empty FIFO with the decimation phase at 0; checks head then pops it.
  task automatic single(input string tag, input logic [IN_W-1:0] x, input logic [OUT_W-1:0] e);
    cyc(1'b1, x, 1'b0, 1'b0);
    cyc(1'b1, '0, 1'b0, 1'b0);
    expect_head(tag, e);
    cyc(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    int max_lvl;
    rst_in = 1'b0; valid_in = 1'b0; data_in = '0; clear_in = 1'b0; mif.m_ready_in = 1'b0;
    #1 rst_in = 1'b1;
    #1;
    check("rst_valid", 32'(mif.m_valid_out), 32'd0);
    check("rst_data", 32'(mif.m_data_out), 32'd0);
    check("rst_level", 32'(fifo_level_out), 32'd0);
    check("rst_overflow", 32'(overflow_out), 32'd0);
    repeat (2) @(posedge clk_in);
    #2 rst_in = 1'b0;

    // Stream with ready high: keeps 0x100 and 0x300.
    cyc(1'b1, 18'h00100, 1'b0, 1'b1);
    check("stream_lat1", 32'(mif.m_valid_out), 32'd0);
    cyc(1'b1, 18'h00200, 1'b0, 1'b1);
    expect_head("stream_first", 8'h01);
    cyc(1'b1, 18'h00300, 1'b0, 1'b1);
    max_lvl = int'(fifo_level_out);
    cyc(1'b1, 18'h00400, 1'b0, 1'b1);
    expect_head("stream_second", 8'h03);
    if (int'(fifo_level_out) > max_lvl) max_lvl = int'(fifo_level_out);
    cyc(1'b0, '0, 1'b0, 1'b1);
    if (int'(fifo_level_out) > max_lvl) max_lvl = int'(fifo_level_out);
    check("stream_max_level", 32'(max_lvl), 32'd1);

    // Rounding and saturation boundaries.
    single("rnd_180", 18'h00180, (RND_TB != 0) ? 8'h02 : 8'h01);
    single("rnd_ff80", 18'h0FF80, 8'hFF);
    single("sat_12345", 18'h12345, 8'hFF);
    single("sat_3ffff", 18'h3FFFF, 8'hFF);
    single("low_ff", 18'h000FF, (RND_TB != 0) ? 8'h01 : 8'h00);

    // Backpressure: six kept samples into a four-entry FIFO.
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, IN_W'((16 + k) << 8), 1'b0, 1'b0);
      cyc(1'b1, '0, 1'b0, 1'b0);
    end
    cyc(1'b0, '0, 1'b0, 1'b0);
    check("bp_level", 32'(fifo_level_out), 32'd4);
    check("bp_overflow", 32'(overflow_out), 32'd1);
    expect_head("bp_head", 8'h10);
    cyc(1'b1, 18'h02000, 1'b0, 1'b0);
    cyc(1'b1, '0, 1'b0, 1'b1);
    check("full_popwrite_level", 32'(fifo_level_out), 32'd4);
    expect_head("full_popwrite_head", 8'h11);
    repeat (6) cyc(1'b0, '0, 1'b0, 1'b1);

    // Clear with level 3, overflow set and decimation phase 1.
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, IN_W'((48 + k) << 8), 1'b0, 1'b0);
      cyc(1'b1, '0, 1'b0, 1'b0);
    end
    cyc(1'b1, 18'h03F00, 1'b0, 1'b1);
    check("pre_clear_level", 32'(fifo_level_out), 32'd3);
    cyc(1'b1, 18'h05500, 1'b1, 1'b0);
    check("clear_level", 32'(fifo_level_out), 32'd0);
    check("clear_valid", 32'(mif.m_valid_out), 32'd0);
    check("clear_overflow", 32'(overflow_out), 32'd0);
    cyc(1'b1, 18'h04200, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    expect_head("post_clear", 8'h42);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a cycle with data buffered and in flight.
    cyc(1'b1, 18'h05000, 1'b0, 1'b0);
    cyc(1'b1, '0, 1'b0, 1'b0);
    cyc(1'b1, 18'h06000, 1'b0, 1'b0);
    #1 rst_in = 1'b1;
    #1;
    check("async_rst_valid", 32'(mif.m_valid_out), 32'd0);
    check("async_rst_data", 32'(mif.m_data_out), 32'd0);
    check("async_rst_level", 32'(fifo_level_out), 32'd0);
    @(posedge clk_in);
    #2 rst_in = 1'b0;
    cyc(1'b0, '0, 1'b0, 1'b0);
    check("after_rst_valid", 32'(mif.m_valid_out), 32'd0);

    // Random traffic with random backpressure and occasional clears.
    for (int i = 0; i < 400; i++) begin
      logic [IN_W-1:0] d;
      case ($urandom_range(0, 3))
        0: d = IN_W'($urandom_range(0, 32'h3FFFF));
        1: d = IN_W'($urandom_range(0, 1023));
        2: d = IN_W'($urandom_range(32'hFF00, 32'h100FF));
        default: d = IN_W'($urandom_range(32'h10000, 32'h3FFFF));
      endcase
      cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 60) == 0, $urandom_range(0, 2) != 0);
    end
    repeat (10) cyc(1'b0, '0, 1'b0, 1'b1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
